// File: rtl/periph_axi_master.sv
// periph_axi_master: single-outstanding AXI4-Lite master for the peripheral window.
// Converts StartAXIRead/StartAXIWrite requests into one AXI4-Lite transaction and
// returns ReadData plus one-cycle ReadCompleted/WriteCompleted pulses.
// Ports: Clk, Rst (async, active-low); request side StartAXIRead, StartAXIWrite,
// AXIAddr, WriteData; response side ReadData, ReadCompleted, WriteCompleted, RespErr;
// AXI4-Lite master channels M_AW*, M_W*, M_B*, M_AR*, M_R*.
// Optional watchdog: define PERIPH_AXI_TIMEOUT_EN to abort a stalled transaction
// after TIMEOUT_CYCLES busy cycles (RespErr=1, ReadData=0xDEADBEEF on reads).
module periph_axi_master #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                StartAXIRead,
  input  logic                StartAXIWrite,
  input  logic [ADDR_W-1:0]   AXIAddr,
  input  logic [DATA_W-1:0]   WriteData,
  output logic [DATA_W-1:0]   ReadData,
  output logic                ReadCompleted,
  output logic                WriteCompleted,
  output logic                RespErr,
  output logic [ADDR_W-1:0]   M_AWADDR,
  output logic [2:0]          M_AWPROT,
  output logic                M_AWVALID,
  input  logic                M_AWREADY,
  output logic [DATA_W-1:0]   M_WDATA,
  output logic [DATA_W/8-1:0] M_WSTRB,
  output logic                M_WVALID,
  input  logic                M_WREADY,
  input  logic [1:0]          M_BRESP,
  input  logic                M_BVALID,
  output logic                M_BREADY,
  output logic [ADDR_W-1:0]   M_ARADDR,
  output logic [2:0]          M_ARPROT,
  output logic                M_ARVALID,
  input  logic                M_ARREADY,
  input  logic [DATA_W-1:0]   M_RDATA,
  input  logic [1:0]          M_RRESP,
  input  logic                M_RVALID,
  output logic                M_RREADY
);
  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, DONE} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic aw_done_q, aw_done_d, w_done_q, w_done_d, err_q, err_d, is_wr_q, is_wr_d;
  logic timeout;
  // Error flag is resp[1]; written as resp[1] & |resp so the whole response field is consumed.
  logic b_err, r_err;
  assign b_err = M_BRESP[1] & |M_BRESP;
  assign r_err = M_RRESP[1] & |M_RRESP;
`ifdef PERIPH_AXI_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d = state_q == IDLE ? '0 : state_q == DONE ? cnt_q : cnt_q + 1'b1;
    timeout = state_q != IDLE && state_q != DONE && cnt_q == CNT_W'(TIMEOUT_CYCLES - 1);
  end
  always_ff @(posedge Clk or negedge Rst)
    if (!Rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
`else
  always_comb timeout = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    aw_done_d = aw_done_q;
    w_done_d = w_done_q;
    err_d = err_q;
    is_wr_d = is_wr_q;
    case (state_q)
      IDLE: begin
        if (StartAXIWrite) begin
          addr_d = AXIAddr;
          wdata_d = WriteData;
          is_wr_d = 1'b1;
          aw_done_d = 1'b0;
          w_done_d = 1'b0;
          state_d = WR_REQ;
        end else if (StartAXIRead) begin
          addr_d = AXIAddr;
          is_wr_d = 1'b0;
          state_d = RD_REQ;
        end
      end
      WR_REQ: begin
        // AW and W handshake independently; leave once both have completed.
        aw_done_d = aw_done_q | M_AWREADY;
        w_done_d = w_done_q | M_WREADY;
        state_d = aw_done_d && w_done_d ? WR_RESP : WR_REQ;
      end
      WR_RESP: begin
        if (M_BVALID) begin
          err_d = b_err;
          state_d = DONE;
        end
      end
      RD_REQ: state_d = M_ARREADY ? RD_DATA : RD_REQ;
      RD_DATA: begin
        if (M_RVALID) begin
          rdata_d = M_RDATA;
          err_d = r_err;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (timeout) begin
      state_d = DONE;
      err_d = 1'b1;
      rdata_d = is_wr_q ? rdata_q : DATA_W'(32'hDEADBEEF);
    end
  end
  always_ff @(posedge Clk or negedge Rst)
    if (!Rst) begin
      state_q <= IDLE;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      aw_done_q <= 1'b0;
      w_done_q <= 1'b0;
      err_q <= 1'b0;
      is_wr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      aw_done_q <= aw_done_d;
      w_done_q <= w_done_d;
      err_q <= err_d;
      is_wr_q <= is_wr_d;
    end
  assign M_AWADDR = addr_q;
  assign M_AWPROT = 3'b000;
  assign M_AWVALID = state_q == WR_REQ && !aw_done_q;
  assign M_WDATA = wdata_q;
  assign M_WSTRB = '1;
  assign M_WVALID = state_q == WR_REQ && !w_done_q;
  assign M_BREADY = state_q == WR_RESP;
  assign M_ARADDR = addr_q;
  assign M_ARPROT = 3'b000;
  assign M_ARVALID = state_q == RD_REQ;
  assign M_RREADY = state_q == RD_DATA;
  assign ReadData = rdata_q;
  assign ReadCompleted = state_q == DONE && !is_wr_q;
  assign WriteCompleted = state_q == DONE && is_wr_q;
  assign RespErr = err_q;
endmodule
